// File: rtl/id_ex_reg_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_reg_pkg
// Shared definitions for the ID/EX boundary of the 5-stage RV32I core.
// The main decoder and the ID/EX register both use ctrl_t, so a pipeline
// bubble is just the CTRL_NOP constant.
// -----------------------------------------------------------------------------
package id_ex_reg_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int FUNCT_W = 10;  // {funct7, funct3}

  // Writeback source select (MemtoReg)
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // ALU operation class (ALUOp)
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // Decoder control word, carried unchanged from ID into EX.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard term. Raised when the instruction in EX is a
// valid load writing a non-zero register that the valid instruction in ID
// names as rs1 or rs2. Both source fields are compared whatever the format,
// which can produce a harmless extra bubble but never misses a real hazard.
//
// Ports:
//   id_valid       ID holds a real instruction
//   ex_valid       EX holds a real instruction
//   ex_mem_read    EX instruction reads memory (load)
//   ex_reg_write   EX instruction writes the register file
//   ex_rd          EX destination register
//   id_rs1/id_rs2  ID source registers
//   haz            load-use hazard present
// -----------------------------------------------------------------------------
module load_use_detect
  import id_ex_reg_pkg::*;
#(
  parameter int RADDR_W = id_ex_reg_pkg::RADDR_W
) (
  input  logic               id_valid,
  input  logic               ex_valid,
  input  logic               ex_mem_read,
  input  logic               ex_reg_write,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  output logic               haz
);

  logic ex_is_load;
  logic rd_match;

  // A load to x0 writes nothing, so it can never be a producer.
  assign ex_is_load = ex_valid & ex_mem_read & ex_reg_write & (ex_rd != '0);
  assign rd_match   = (ex_rd == id_rs1) | (ex_rd == id_rs2);
  assign haz        = id_valid & ex_is_load & rd_match;

endmodule

// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
// ID/EX pipeline register of the RV32I core. Captures the decoder control
// word, operands, immediate, PC and register indices at the end of ID and
// presents them to EX one cycle later. Inserts a single bubble on a load-use
// hazard (and asks the front end to hold), inserts a bubble on a taken
// branch/jump flush, freezes completely on stall_i, and keeps a saturating
// count of load-use bubbles.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   stall_i                    global freeze, everything holds
//   flush_i                    EX redirect, ID instruction discarded
//   id_valid_i                 ID holds a real instruction
//   *_i control/data           decoder outputs and ID operands
//   *_o control/data           registered copies for EX
//   valid_o                    EX holds a real instruction
//   load_use_stall_o           combinational, hold PC and IF/ID this cycle
//   bubble_cnt_o               saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int XLEN    = id_ex_reg_pkg::XLEN,
  parameter int RADDR_W = id_ex_reg_pkg::RADDR_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               id_valid_i,
  input  logic               RegWrite_i,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  input  logic               ALUSrc_i,
  input  logic               Branch_i,
  input  logic               jump_i,
  input  logic [1:0]         MemtoReg_i,
  input  logic [1:0]         ALUOp_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [XLEN-1:0]    rs2_data_i,
  input  logic [XLEN-1:0]    imm_i,
  input  logic [RADDR_W-1:0] rs1_addr_i,
  input  logic [RADDR_W-1:0] rs2_addr_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic [9:0]         funct_i,
  output logic               RegWrite_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               ALUSrc_o,
  output logic               Branch_o,
  output logic               jump_o,
  output logic [1:0]         MemtoReg_o,
  output logic [1:0]         ALUOp_o,
  output logic [XLEN-1:0]    pc_o,
  output logic [XLEN-1:0]    rs1_data_o,
  output logic [XLEN-1:0]    rs2_data_o,
  output logic [XLEN-1:0]    imm_o,
  output logic [RADDR_W-1:0] rs1_addr_o,
  output logic [RADDR_W-1:0] rs2_addr_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic [9:0]         funct_o,
  output logic               valid_o,
  output logic               load_use_stall_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t              ctrl_d;
  ctrl_t              ctrl_q;
  logic               valid_q;
  logic [XLEN-1:0]    pc_q;
  logic [XLEN-1:0]    rs1_data_q;
  logic [XLEN-1:0]    rs2_data_q;
  logic [XLEN-1:0]    imm_q;
  logic [RADDR_W-1:0] rs1_addr_q;
  logic [RADDR_W-1:0] rs2_addr_q;
  logic [RADDR_W-1:0] rd_addr_q;
  logic [9:0]         funct_q;
  logic [CNT_W-1:0]   bubble_cnt_q;
  logic               haz;

  assign ctrl_d = '{
    reg_write:  RegWrite_i,
    mem_read:   MemRead_i,
    mem_write:  MemWrite_i,
    alu_src:    ALUSrc_i,
    branch:     Branch_i,
    jump:       jump_i,
    mem_to_reg: MemtoReg_i,
    alu_op:     ALUOp_i
  };

  load_use_detect #(
    .RADDR_W (RADDR_W)
  ) u_load_use_detect (
    .id_valid     (id_valid_i),
    .ex_valid     (valid_q),
    .ex_mem_read  (ctrl_q.mem_read),
    .ex_reg_write (ctrl_q.reg_write),
    .ex_rd        (rd_addr_q),
    .id_rs1       (rs1_addr_i),
    .id_rs2       (rs2_addr_i),
    .haz          (haz)
  );

  // A flush already discards the ID instruction, so there is nothing to hold.
  // stall_i is deliberately not folded in: the front end combines the two.
  assign load_use_stall_o = haz & ~flush_i;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values; the hold on stall_i is simply an
  // unassigned branch, which in a clocked block is a flop enable, not a latch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: this is a handful of flops, not a memory, so the whole register
      // and the counter are cleared; EX must never see stale content.
      ctrl_q       <= CTRL_NOP;
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rd_addr_q    <= '0;
      funct_q      <= '0;
      bubble_cnt_q <= '0;
    end else if (!stall_i) begin
      if (flush_i || haz) begin
        ctrl_q     <= CTRL_NOP;
        valid_q    <= 1'b0;
        pc_q       <= '0;
        rs1_data_q <= '0;
        rs2_data_q <= '0;
        imm_q      <= '0;
        rs1_addr_q <= '0;
        rs2_addr_q <= '0;
        rd_addr_q  <= '0;
        funct_q    <= '0;
        // Only load-use bubbles are counted, and the count never wraps.
        if (!flush_i && bubble_cnt_q != CNT_MAX) begin
          bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
      end else begin
        // Fields load even when id_valid_i is low; valid_q alone qualifies them.
        ctrl_q     <= ctrl_d;
        valid_q    <= id_valid_i;
        pc_q       <= pc_i;
        rs1_data_q <= rs1_data_i;
        rs2_data_q <= rs2_data_i;
        imm_q      <= imm_i;
        rs1_addr_q <= rs1_addr_i;
        rs2_addr_q <= rs2_addr_i;
        rd_addr_q  <= rd_addr_i;
        funct_q    <= funct_i;
      end
    end
  end

  assign RegWrite_o   = ctrl_q.reg_write;
  assign MemRead_o    = ctrl_q.mem_read;
  assign MemWrite_o   = ctrl_q.mem_write;
  assign ALUSrc_o     = ctrl_q.alu_src;
  assign Branch_o     = ctrl_q.branch;
  assign jump_o       = ctrl_q.jump;
  assign MemtoReg_o   = ctrl_q.mem_to_reg;
  assign ALUOp_o      = ctrl_q.alu_op;
  assign valid_o      = valid_q;
  assign pc_o         = pc_q;
  assign rs1_data_o   = rs1_data_q;
  assign rs2_data_o   = rs2_data_q;
  assign imm_o        = imm_q;
  assign rs1_addr_o   = rs1_addr_q;
  assign rs2_addr_o   = rs2_addr_q;
  assign rd_addr_o    = rd_addr_q;
  assign funct_o      = funct_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg
// Directed bench for id_ex_reg with a 2-bit bubble counter so saturation is
// reached quickly. Inputs change 1 ns after the rising edge and outputs are
// checked there as well.
// -----------------------------------------------------------------------------
module tb_id_ex_reg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int CNT_W   = 2;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               stall_i;
  logic               flush_i;
  logic               id_valid_i;
  logic               RegWrite_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i, jump_i;
  logic [1:0]         MemtoReg_i, ALUOp_i;
  logic [XLEN-1:0]    pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [RADDR_W-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [9:0]         funct_i;
  logic               RegWrite_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o, jump_o;
  logic [1:0]         MemtoReg_o, ALUOp_o;
  logic [XLEN-1:0]    pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [RADDR_W-1:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [9:0]         funct_o;
  logic               valid_o;
  logic               load_use_stall_o;
  logic [CNT_W-1:0]   bubble_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  id_ex_reg #(
    .XLEN    (XLEN),
    .RADDR_W (RADDR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .id_valid_i       (id_valid_i),
    .RegWrite_i       (RegWrite_i),
    .MemRead_i        (MemRead_i),
    .MemWrite_i       (MemWrite_i),
    .ALUSrc_i         (ALUSrc_i),
    .Branch_i         (Branch_i),
    .jump_i           (jump_i),
    .MemtoReg_i       (MemtoReg_i),
    .ALUOp_i          (ALUOp_i),
    .pc_i             (pc_i),
    .rs1_data_i       (rs1_data_i),
    .rs2_data_i       (rs2_data_i),
    .imm_i            (imm_i),
    .rs1_addr_i       (rs1_addr_i),
    .rs2_addr_i       (rs2_addr_i),
    .rd_addr_i        (rd_addr_i),
    .funct_i          (funct_i),
    .RegWrite_o       (RegWrite_o),
    .MemRead_o        (MemRead_o),
    .MemWrite_o       (MemWrite_o),
    .ALUSrc_o         (ALUSrc_o),
    .Branch_o         (Branch_o),
    .jump_o           (jump_o),
    .MemtoReg_o       (MemtoReg_o),
    .ALUOp_o          (ALUOp_o),
    .pc_o             (pc_o),
    .rs1_data_o       (rs1_data_o),
    .rs2_data_o       (rs2_data_o),
    .imm_o            (imm_o),
    .rs1_addr_o       (rs1_addr_o),
    .rs2_addr_o       (rs2_addr_o),
    .rd_addr_o        (rd_addr_o),
    .funct_o          (funct_o),
    .valid_o          (valid_o),
    .load_use_stall_o (load_use_stall_o),
    .bubble_cnt_o     (bubble_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one instruction in ID; operand data is derived from the PC.
  task automatic drive_id(input logic v, input logic rw, input logic mr,
                          input logic [1:0] m2r, input logic [1:0] aop,
                          input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] imm);
    id_valid_i = v;
    RegWrite_i = rw;
    MemRead_i  = mr;
    MemWrite_i = 1'b0;
    ALUSrc_i   = mr;
    Branch_i   = 1'b0;
    jump_i     = 1'b0;
    MemtoReg_i = m2r;
    ALUOp_i    = aop;
    pc_i       = pc;
    rs1_data_i = pc ^ 32'hA5A5_0000;
    rs2_data_i = pc ^ 32'h0000_5A5A;
    imm_i      = imm;
    rs1_addr_i = rs1;
    rs2_addr_i = rs2;
    rd_addr_i  = rd;
    funct_i    = 10'h000;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, " valid"}, 32'(valid_o), 32'd0);
    check({tag, " ctrl"}, 32'({RegWrite_o, MemRead_o, MemWrite_o, ALUSrc_o,
                               Branch_o, jump_o, MemtoReg_o, ALUOp_o}), 32'd0);
    check({tag, " pc"}, pc_o, 32'd0);
    check({tag, " rd"}, 32'(rd_addr_o), 32'd0);
  endtask

  initial begin
    // ---- 1. Reset with random inputs, including stall and flush ----
    rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      stall_i    = 1'($urandom);
      flush_i    = 1'($urandom);
      drive_id(1'b1, 1'b1, 1'($urandom), 2'($urandom), 2'($urandom), $urandom,
               5'($urandom), 5'($urandom), 5'($urandom), $urandom);
      Branch_i   = 1'b1;
      jump_i     = 1'b1;
      funct_i    = 10'($urandom);
      tick();
    end
    check("rst valid", 32'(valid_o), 32'd0);
    check("rst ctrl", 32'({RegWrite_o, MemRead_o, MemWrite_o, ALUSrc_o,
                           Branch_o, jump_o, MemtoReg_o, ALUOp_o}), 32'd0);
    check("rst pc", pc_o, 32'd0);
    check("rst rs1_data", rs1_data_o, 32'd0);
    check("rst imm", imm_o, 32'd0);
    check("rst addrs", 32'({rs1_addr_o, rs2_addr_o, rd_addr_o}), 32'd0);
    check("rst funct", 32'(funct_o), 32'd0);
    check("rst cnt", 32'(bubble_cnt_o), 32'd0);
    check("rst lus", 32'(load_use_stall_o), 32'd0);

    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;

    // ---- 2. add x3,x1,x2 at 0x40 ----
    drive_id(1'b1, 1'b1, 1'b0, 2'd0, 2'b10, 32'h40, 5'd1, 5'd2, 5'd3, 32'h0);
    funct_i = 10'h155;
    tick();
    check("add pc", pc_o, 32'h40);
    check("add rd", 32'(rd_addr_o), 32'd3);
    check("add aluop", 32'(ALUOp_o), 32'h2);
    check("add valid", 32'(valid_o), 32'd1);
    check("add regwrite", 32'(RegWrite_o), 32'd1);
    check("add rs1_data", rs1_data_o, 32'hA5A5_0040);
    check("add rs2_data", rs2_data_o, 32'h0000_5A1A);
    check("add funct", 32'(funct_o), 32'h155);
    check("add lus", 32'(load_use_stall_o), 32'd0);

    // ---- 3. lw x5,4(x1) then add x6,x1,x5 ----
    drive_id(1'b1, 1'b1, 1'b1, 2'd1, 2'b00, 32'h44, 5'd1, 5'd0, 5'd5, 32'h4);
    tick();
    check("lw memread", 32'(MemRead_o), 32'd1);
    check("lw memtoreg", 32'(MemtoReg_o), 32'd1);
    check("lw imm", imm_o, 32'h4);
    drive_id(1'b1, 1'b1, 1'b0, 2'd0, 2'b10, 32'h48, 5'd1, 5'd5, 5'd6, 32'h0);
    #1;
    check("lu lus", 32'(load_use_stall_o), 32'd1);
    tick();
    check_bubble("lu bubble");
    check("lu cnt", 32'(bubble_cnt_o), 32'd1);
    check("lu lus after", 32'(load_use_stall_o), 32'd0);
    tick();
    check("lu held pc", pc_o, 32'h48);
    check("lu held valid", 32'(valid_o), 32'd1);
    check("lu held rs2", 32'(rs2_addr_o), 32'd5);

    // ---- 4a. lw x0 then a jal-like use of x0 ----
    drive_id(1'b1, 1'b1, 1'b1, 2'd1, 2'b00, 32'h4C, 5'd1, 5'd0, 5'd0, 32'h0);
    tick();
    drive_id(1'b1, 1'b1, 1'b0, 2'd2, 2'b00, 32'h50, 5'd0, 5'd0, 5'd7, 32'h8);
    jump_i = 1'b1;
    #1;
    check("x0 lus", 32'(load_use_stall_o), 32'd0);
    tick();
    check("x0 pc", pc_o, 32'h50);
    check("x0 jump", 32'(jump_o), 32'd1);
    check("x0 memtoreg", 32'(MemtoReg_o), 32'd2);
    check("x0 cnt", 32'(bubble_cnt_o), 32'd1);

    // ---- 4b. add x5 then a use of x5 ----
    drive_id(1'b1, 1'b1, 1'b0, 2'd0, 2'b10, 32'h54, 5'd1, 5'd2, 5'd5, 32'h0);
    tick();
    drive_id(1'b1, 1'b1, 1'b0, 2'd0, 2'b10, 32'h58, 5'd5, 5'd2, 5'd8, 32'h0);
    #1;
    check("alu lus", 32'(load_use_stall_o), 32'd0);
    tick();
    check("alu pc", pc_o, 32'h58);
    check("alu valid", 32'(valid_o), 32'd1);

    // ---- 5. load-use hazard together with a flush ----
    drive_id(1'b1, 1'b1, 1'b1, 2'd1, 2'b00, 32'h60, 5'd1, 5'd0, 5'd5, 32'h0);
    tick();
    drive_id(1'b1, 1'b1, 1'b0, 2'd0, 2'b10, 32'h64, 5'd2, 5'd5, 5'd9, 32'h0);
    flush_i = 1'b1;
    #1;
    check("fl lus", 32'(load_use_stall_o), 32'd0);
    tick();
    check_bubble("fl bubble");
    check("fl cnt", 32'(bubble_cnt_o), 32'd1);
    flush_i = 1'b0;
    tick();
    check("fl next pc", pc_o, 32'h64);
    check("fl next valid", 32'(valid_o), 32'd1);

    // ---- 6a. freeze for 3 cycles with changing inputs ----
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, 1'b0, 1'b1, 2'd1, 2'b11, 32'h100 + 32'(i), 5'd3, 5'd4, 5'(10 + i), 32'h7);
      tick();
      check("frz pc", pc_o, 32'h64);
      check("frz rd", 32'(rd_addr_o), 32'd9);
      check("frz valid", 32'(valid_o), 32'd1);
      check("frz memread", 32'(MemRead_o), 32'd0);
      check("frz cnt", 32'(bubble_cnt_o), 32'd1);
    end
    stall_i = 1'b0;

    // ---- 6b. four load-use events, counter saturates at 3 ----
    for (int i = 0; i < 4; i++) begin
      drive_id(1'b1, 1'b1, 1'b1, 2'd1, 2'b00, 32'h200 + 32'(8 * i), 5'd1, 5'd0, 5'd9, 32'h0);
      tick();
      drive_id(1'b1, 1'b1, 1'b0, 2'd0, 2'b10, 32'h204 + 32'(8 * i), 5'd9, 5'd2, 5'd11, 32'h0);
      #1;
      check("sat lus", 32'(load_use_stall_o), 32'd1);
      if (i == 0) begin
        // A freeze during a hazard holds the load and does not count.
        stall_i = 1'b1;
        tick();
        check("sat frz memread", 32'(MemRead_o), 32'd1);
        check("sat frz cnt", 32'(bubble_cnt_o), 32'd1);
        check("sat frz lus", 32'(load_use_stall_o), 32'd1);
        stall_i = 1'b0;
      end
      tick();
      check("sat valid", 32'(valid_o), 32'd0);
      check("sat cnt", 32'(bubble_cnt_o), (i == 0) ? 32'd2 : 32'd3);
    end

    // ---- reset during freeze and flush leaves an empty register ----
    drive_id(1'b1, 1'b1, 1'b0, 2'd0, 2'b10, 32'h300, 5'd1, 5'd2, 5'd3, 32'h0);
    tick();
    check("pre-rst valid", 32'(valid_o), 32'd1);
    rst_i = 1'b1; stall_i = 1'b1; flush_i = 1'b1;
    tick();
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    check("mid rst valid", 32'(valid_o), 32'd0);
    check("mid rst pc", pc_o, 32'd0);
    check("mid rst cnt", 32'(bubble_cnt_o), 32'd0);

    // ---- id_valid low: fields load, valid_o stays 0 ----
    drive_id(1'b0, 1'b1, 1'b1, 2'd1, 2'b00, 32'h400, 5'd1, 5'd0, 5'd12, 32'h0);
    tick();
    check("inv pc", pc_o, 32'h400);
    check("inv valid", 32'(valid_o), 32'd0);
    drive_id(1'b1, 1'b1, 1'b0, 2'd0, 2'b10, 32'h404, 5'd12, 5'd0, 5'd13, 32'h0);
    #1;
    check("inv lus", 32'(load_use_stall_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
